// File: rtl/add_mul_sequencer_if.sv
// Request/response bundle for add_mul_sequencer: operands and control in, status and result out.
// Signal names inside the bundle match the block's port names.
interface add_mul_sequencer_if;
    logic        start;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        abort;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, op, a, b, cin, abort,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b, cin, abort,
        output busy, done, result
    );
endinterface

// File: rtl/add_mul_sequencer.sv
// Sequenced arithmetic unit: a single-cycle 16-bit add with carry-in, or a
// 16-step shift-add unsigned multiply; result is held until the next accepted start.
module add_mul_sequencer (
    input  logic               clk,
    input  logic               rst,
    add_mul_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic        op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        cin_q, cin_d;
    logic [31:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;

    logic [16:0] sum;
    logic [31:0] partial;
    logic [31:0] acc_next;

    assign sum      = {1'b0, a_q} + {1'b0, b_q} + {16'b0, cin_q};
    assign partial  = b_q[cnt_q] ? ({16'b0, a_q} << cnt_q) : 32'd0;
    assign acc_next = acc_q + partial;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                // Abort outranks start, so a coinciding request is dropped.
                if (bus.start && !bus.abort) begin
                    op_d    = bus.op;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    cin_d   = bus.cin;
                    acc_d   = 32'd0;
                    cnt_d   = 4'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (!op_q) begin
                    result_d = {15'd0, sum};
                    state_d  = DONE;
                end else begin
                    acc_d = acc_next;
                    cnt_d = cnt_q + 4'd1;
                    // The last step writes its own sum straight to result; the accumulator is never exposed.
                    if (cnt_q == 4'd15) begin
                        result_d = acc_next;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the captured operands are reset too; this is a handful of flops, not a memory array.
            state_q  <= IDLE;
            op_q     <= 1'b0;
            a_q      <= 16'd0;
            b_q      <= 16'd0;
            cin_q    <= 1'b0;
            acc_q    <= 32'd0;
            cnt_q    <= 4'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
endmodule

// File: tb/tb_add_mul_sequencer.sv
// Self-checking bench for add_mul_sequencer: directed corner cases plus randomized
// operations checked against plain-arithmetic expectations and fixed latencies.
module tb_add_mul_sequencer;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [31:0] model_result;

    add_mul_sequencer_if bus_if ();

    add_mul_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] expect_of(input logic op, input logic [15:0] a,
                                              input logic [15:0] b, input logic cin);
        if (op) return {16'd0, a} * {16'd0, b};
        return {16'd0, a} + {16'd0, b} + {31'd0, cin};
    endfunction

    // One full operation: start sampled at edge N, done expected exactly L cycles later.
    task automatic run_op(input logic op, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input bit noise);
        logic [31:0] exp;
        int lat;
        exp = expect_of(op, a, b, cin);
        lat = op ? 16 : 1;
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.op    = op;
        bus_if.a     = a;
        bus_if.b     = b;
        bus_if.cin   = cin;
        step();
        check("busy_after_accept", {31'd0, bus_if.busy}, 32'd1);
        for (int k = 1; k <= lat; k++) begin
            bus_if.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus_if.op    = 1'($urandom);
            bus_if.a     = 16'($urandom);
            bus_if.b     = 16'($urandom);
            bus_if.cin   = 1'($urandom);
            step();
            if (k < lat) begin
                check("done_early", {31'd0, bus_if.done}, 32'd0);
                check("result_held", bus_if.result, model_result);
            end else begin
                check("done_pulse", {31'd0, bus_if.done}, 32'd1);
                check("busy_in_done", {31'd0, bus_if.busy}, 32'd1);
                check(op ? "mul_result" : "add_result", bus_if.result, exp);
            end
        end
        step();
        bus_if.start = 1'b0;
        check("done_single", {31'd0, bus_if.done}, 32'd0);
        check("idle_after", {31'd0, bus_if.busy}, 32'd0);
        model_result = exp;
    endtask

    initial begin
        logic [31:0] exp_b2b;
        n_checks = 0;
        n_fail   = 0;
        model_result = 32'd0;
        bus_if.start = 1'b0;
        bus_if.op    = 1'b0;
        bus_if.a     = 16'd0;
        bus_if.b     = 16'd0;
        bus_if.cin   = 1'b0;
        bus_if.abort = 1'b0;
        rst = 1'b1;
        #12;
        check("reset_busy", {31'd0, bus_if.busy}, 32'd0);
        check("reset_done", {31'd0, bus_if.done}, 32'd0);
        check("reset_result", bus_if.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed corner cases.
        run_op(1'b0, 16'hFFFF, 16'h0001, 1'b1, 1'b0);
        run_op(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        run_op(1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0);
        run_op(1'b1, 16'd7, 16'd9, 1'b0, 1'b0);
        run_op(1'b1, 16'd7, 16'd9, 1'b0, 1'b1);

        // Abort at edge N+8 of 100*200 with prior result 0x42.
        run_op(1'b0, 16'h0040, 16'h0002, 1'b0, 1'b0);
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.op = 1'b1; bus_if.a = 16'd100; bus_if.b = 16'd200;
        step();
        bus_if.start = 1'b0;
        repeat (7) step();
        bus_if.abort = 1'b1;
        step();
        bus_if.abort = 1'b0;
        check("abort_idle", {31'd0, bus_if.busy}, 32'd0);
        check("abort_no_done", {31'd0, bus_if.done}, 32'd0);
        check("abort_result_kept", bus_if.result, 32'h0000_0042);
        step();
        check("abort_no_late_done", {31'd0, bus_if.done}, 32'd0);

        // Abort coinciding with the completing multiply step.
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.op = 1'b1; bus_if.a = 16'd3; bus_if.b = 16'd4;
        step();
        bus_if.start = 1'b0;
        repeat (15) step();
        bus_if.abort = 1'b1;
        step();
        bus_if.abort = 1'b0;
        check("abort_at_completion_done", {31'd0, bus_if.done}, 32'd0);
        check("abort_at_completion_result", bus_if.result, 32'h0000_0042);

        // Abort with start in IDLE: nothing accepted.
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.abort = 1'b1; bus_if.op = 1'b0;
        step();
        bus_if.start = 1'b0; bus_if.abort = 1'b0;
        check("abort_beats_start", {31'd0, bus_if.busy}, 32'd0);

        // Asynchronous reset mid-multiply.
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.op = 1'b1; bus_if.a = 16'd50; bus_if.b = 16'd60;
        step();
        bus_if.start = 1'b0;
        repeat (4) step();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", {31'd0, bus_if.busy}, 32'd0);
        check("async_rst_done", {31'd0, bus_if.done}, 32'd0);
        check("async_rst_result", bus_if.result, 32'd0);
        model_result = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b0, 16'd2, 16'd3, 1'b0, 1'b0);

        // Back-to-back adds with start held high: one accept every third edge.
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.op = 1'b0; bus_if.a = 16'($urandom); bus_if.b = 16'($urandom); bus_if.cin = 1'($urandom);
        for (int j = 0; j < 4; j++) begin
            exp_b2b = expect_of(1'b0, bus_if.a, bus_if.b, bus_if.cin);
            step();
            check("b2b_accept", {31'd0, bus_if.busy}, 32'd1);
            check("b2b_no_done", {31'd0, bus_if.done}, 32'd0);
            bus_if.a = 16'($urandom); bus_if.b = 16'($urandom); bus_if.cin = 1'($urandom);
            step();
            check("b2b_done", {31'd0, bus_if.done}, 32'd1);
            check("b2b_sum", bus_if.result, exp_b2b);
            step();
            check("b2b_idle", {31'd0, bus_if.busy}, 32'd0);
            if (j == 3) bus_if.start = 1'b0;
        end
        model_result = exp_b2b;

        // Randomized operations with stray start pulses while busy.
        for (int i = 0; i < 24; i++) begin
            run_op(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/add_mul_sequencer.md
ADD_MUL_SEQUENCER -- requirements
Module: add_mul_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: operation request; sampled only in IDLE.
REQ-004 SHALL have port op, input, 1 bit: 0 = add, 1 = unsigned multiply; captured with start.
REQ-005 SHALL have ports a and b, input, 16 bits each: operands; captured with start.
REQ-006 SHALL have port cin, input, 1 bit: add carry-in; captured with start; ignored for multiply.
REQ-007 SHALL have port abort, input, 1 bit: synchronous cancel of an in-flight operation.
REQ-008 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port result, output, 32 bits: registered result, held until the next accepted start.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 SHALL accept start only at a rising edge where state = IDLE and abort = 0; the edge where start is sampled is edge N.
REQ-013 SHALL, on acceptance at edge N, latch op, a, b, cin, clear the accumulator and step counter, and enter RUN.
REQ-014 SHALL ignore start while busy; no queuing, no effect on the latched operands.
REQ-015 SHALL treat operand/op/cin changes after edge N as don't-care for the current operation.
REQ-016 SHALL, for add, compute result = zero-extended 17-bit (a + b + cin) at edge N+1, bits 31:17 = 0, then enter DONE.
REQ-017 SHALL, for multiply, perform one shift-add step per cycle for 16 cycles: step i (i = 0..15) adds (a << i) to a 32-bit accumulator when b[i] = 1.
REQ-018 SHALL use a 4-bit step counter that wraps from 15 to 0; the step at count 15 (edge N+16) writes result = a*b (unsigned, exact, no overflow) and enters DONE.
REQ-019 SHALL assert done for exactly the one cycle in DONE, i.e. after edge N+1 (add) or N+16 (multiply), and return to IDLE on the next edge.
REQ-020 SHALL, when abort = 1 at an edge in RUN or DONE, return to IDLE, leave result unchanged from its previous value, and not produce a done pulse in the following cycle.
REQ-021 SHALL give abort priority over start and over completion when they coincide; abort in IDLE has no effect.
REQ-022 SHALL permit a new start at the first edge after returning to IDLE (minimum start-to-start: 3 edges add, 18 edges multiply).
REQ-023 SHALL update result only at completion; intermediate accumulator values never appear on result.

Reset
REQ-024 SHALL, while rst = 1, immediately force state = IDLE, busy = 0, done = 0, result = 0, accumulator = 0, counter = 0, independent of clk.
REQ-025 SHALL, on rst assertion mid-operation, discard the operation without a done pulse; first start is accepted at the first rising edge after rst deasserts.

Verification
REQ-026 SHALL pass: add a=16'hFFFF, b=16'h0001, cin=1 -> done one cycle after edge N+1, result=32'h0001_0001, busy high for 2 cycles.
REQ-027 SHALL pass: multiply a=16'hFFFF, b=16'hFFFF -> done after edge N+16, result=32'hFFFE_0001; multiply a=16'h1234, b=0 -> result=0.
REQ-028 SHALL pass: start pulsed with a=3,b=5 during a running multiply of 7*9 -> second request ignored, result=63, single done pulse.
REQ-029 SHALL pass: abort asserted at edge N+8 of multiply 100*200 with prior result 32'h0000_0042 -> IDLE next cycle, no done, result stays 32'h0000_0042.
REQ-030 SHALL pass: rst asserted asynchronously mid-multiply -> busy, done, result go to 0 before next clk edge; post-reset add 2+3+0 -> result=5.
REQ-031 SHALL pass: back-to-back adds with start held high -> accepts at every third edge, each producing one done pulse with correct sums.
